mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single DPI-C memory port between two requesters: port 0 is instruction fetch (read-only) and port 1 is load/store (read/write).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block round-robins between the two, sequences one memory access at a time, and returns read data or write completion.
- It sits between the core front-end/LSU and the simulation memory model.

Parameters:
- ADDR_W, 64, address width of requests and memory port
- DATA_W, 64, data width; mask width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r0_req_valid  in  1  fetch request valid
- r0_req_ready  out  1  fetch request accepted this cycle
- r0_req_addr  in  ADDR_W  fetch address
- r0_resp_valid  out  1  fetch data valid
- r0_resp_ready  in  1  fetch consumer ready
- r0_resp_rdata  out  DATA_W  fetch read data
- r1_req_valid  in  1  LSU request valid
- r1_req_ready  out  1  LSU request accepted this cycle
- r1_req_addr  in  ADDR_W  LSU address
- r1_req_wen  in  1  1 = write, 0 = read
- r1_req_wdata  in  DATA_W  write data
- r1_req_wmask  in  DATA_W/8  byte mask
- r1_resp_valid  out  1  LSU response valid
- r1_resp_ready  in  1  LSU consumer ready
- r1_resp_rdata  out  DATA_W  read data (0 for writes)
- r1_resp_err  out  1  illegal write mask; write was dropped
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  combinational read data from memory
- mem_we_en  out  1  memory write enable (sampled at posedge)
- mem_we_addr  out  ADDR_W  write address
- mem_we_data  out  DATA_W  write data
- mem_we_mask  out  DATA_W/8  write mask

Behaviour:
- Reset:
  - Reset is rst, synchronous, active-high; clock is clk.
  - On reset: state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All outputs are 0 during and after reset until a request arrives, including req_ready, resp_valid, mem_* enables, and mem addresses/data.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If exactly one req_valid is high, grant that port.
  - If both are high, grant the port that was not last_grant.
  - The granted req_ready is driven high combinationally; the other port sees req_ready=0.
  - On the handshake edge: latch addr, wen (0 for port 0), wdata, wmask and grant id; update last_grant; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS, one cycle:
  - Read: mem_rd_en=1 and mem_rd_addr=latched addr; mem_rd_data is captured into the response register at the end of the cycle.
  - Write with a legal mask (0x01, 0x03, 0x0F, 0xFF): mem_we_en=1 for exactly this cycle with the latched addr, data and mask. The response rdata is 0 and err is 0.
  - Write with any other mask: mem_we_en stays 0 and err=1.
  - Always go to RESP.
- RESP:
  - Only the granted port's resp_valid=1; rdata and err are held stable.
  - Stay in RESP until resp_ready=1, then go to IDLE.
  - A new request is accepted no earlier than the cycle after leaving RESP.
- Outside ACCESS: mem_rd_en=0, mem_rd_addr=0, mem_we_en=0 and the other mem_we_* outputs=0.
- Timing: handshake at edge N, ACCESS in cycle N+1, resp_valid visible in cycle N+2. Minimum of 3 cycles per transaction.
- Non-granted port outputs: resp_valid=0 and resp_rdata=0.
- Reset mid-transaction:
  - The in-flight request is dropped and no response is produced.
  - If reset is asserted during ACCESS, mem_we_en is forced to 0 in that cycle, so no write occurs.
- A requester may drop or change req_valid or addr without a handshake; the arbiter only latches on a handshake.

Test Plan:
- Port 0 reads 0x80000000 while memory holds 0x0000000100000013 -> r0_req_ready in cycle 0, mem_rd_en=1 with addr 0x80000000 in cycle 1, r0_resp_valid with rdata 0x0000000100000013 in cycle 2. Port 1 outputs stay 0.
- Port 1 writes 0xDEADBEEF to 0x80001000 with mask 0x0F, then reads the same address -> mem_we_en pulses exactly once with mask 0x0F, the write response has rdata=0 and err=0, and the read returns 0x...DEADBEEF in its low 32 bits.
- Both ports valid continuously for 6 transactions after reset -> grants are 0,1,0,1,0,1, with each response delivered before the next grant.
- Port 1 write with mask 0x05 -> mem_we_en never asserts, and r1_resp_valid arrives with err=1 and rdata=0.
- Backpressure: r0_resp_ready held low for 5 cycles -> resp_valid and rdata stay stable, r1 request is not accepted until the cycle after r0_resp_ready=1.
- rst asserted during ACCESS of a port 1 write -> no write reaches memory, no response is produced, and all outputs are 0 the cycle after reset; the first post-reset tie is granted to port 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              r0_req_valid;
    logic              r0_req_ready;
    logic [ADDR_W-1:0] r0_req_addr;
    logic              r0_resp_valid;
    logic              r0_resp_ready;
    logic [DATA_W-1:0] r0_resp_rdata;

    logic              r1_req_valid;
    logic              r1_req_ready;
    logic [ADDR_W-1:0] r1_req_addr;
    logic              r1_req_wen;
    logic [DATA_W-1:0] r1_req_wdata;
    logic [MASK_W-1:0] r1_req_wmask;
    logic              r1_resp_valid;
    logic              r1_resp_ready;
    logic [DATA_W-1:0] r1_resp_rdata;
    logic              r1_resp_err;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_we_en;
    logic [ADDR_W-1:0] mem_we_addr;
    logic [DATA_W-1:0] mem_we_data;
    logic [MASK_W-1:0] mem_we_mask;

    // Arbiter side.
    modport slave (
        input  r0_req_valid, r0_req_addr, r0_resp_ready,
        input  r1_req_valid, r1_req_addr, r1_req_wen, r1_req_wdata, r1_req_wmask, r1_resp_ready,
        input  mem_rd_data,
        output r0_req_ready, r0_resp_valid, r0_resp_rdata,
        output r1_req_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
        output mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
    );

    // Requesters plus memory model side.
    modport master (
        output r0_req_valid, r0_req_addr, r0_resp_ready,
        output r1_req_valid, r1_req_addr, r1_req_wen, r1_req_wdata, r1_req_wmask, r1_resp_ready,
        output mem_rd_data,
        input  r0_req_ready, r0_resp_valid, r0_resp_rdata,
        input  r1_req_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
        input  mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              wen_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata_q;

    logic gnt_valid;
    logic gnt_id;
    logic mask_legal;
    logic access_rd;
    logic access_wr;
    logic resp_r0;
    logic resp_r1;
    logic resp_taken;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (bus.r0_req_valid && bus.r1_req_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant_q;
            end else if (bus.r0_req_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (bus.r1_req_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign mask_legal = (wmask_q == MASK_W'(8'h01)) || (wmask_q == MASK_W'(8'h03)) ||
                        (wmask_q == MASK_W'(8'h0F)) || (wmask_q == MASK_W'(8'hFF));

    // Every output is qualified by !rst so a reset landing mid-access suppresses the write.
    assign access_rd  = (state_q == ACCESS) && !wen_q && !rst;
    assign access_wr  = (state_q == ACCESS) && wen_q && mask_legal && !rst;
    assign resp_r0    = (state_q == RESP) && !grant_q && !rst;
    assign resp_r1    = (state_q == RESP) && grant_q && !rst;
    assign resp_taken = grant_q ? bus.r1_resp_ready : bus.r0_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            wen_q        <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        grant_q      <= gnt_id;
                        last_grant_q <= gnt_id;
                        addr_q       <= gnt_id ? bus.r1_req_addr : bus.r0_req_addr;
                        wen_q        <= gnt_id & bus.r1_req_wen;
                        wdata_q      <= gnt_id ? bus.r1_req_wdata : '0;
                        wmask_q      <= gnt_id ? bus.r1_req_wmask : '0;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= wen_q ? '0 : bus.mem_rd_data;
                    err_q   <= wen_q && !mask_legal;
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_taken) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.r0_req_ready  = gnt_valid && !gnt_id;
    assign bus.r1_req_ready  = gnt_valid && gnt_id;

    assign bus.r0_resp_valid = resp_r0;
    assign bus.r0_resp_rdata = resp_r0 ? rdata_q : '0;
    assign bus.r1_resp_valid = resp_r1;
    assign bus.r1_resp_rdata = resp_r1 ? rdata_q : '0;
    assign bus.r1_resp_err   = resp_r1 && err_q;

    assign bus.mem_rd_en     = access_rd;
    assign bus.mem_rd_addr   = access_rd ? addr_q : '0;
    assign bus.mem_we_en     = access_wr;
    assign bus.mem_we_addr   = access_wr ? addr_q : '0;
    assign bus.mem_we_data   = access_wr ? wdata_q : '0;
    assign bus.mem_we_mask   = access_wr ? wmask_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table, scoreboard and corner sequences for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        port;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_we;
    } vec_t;

    typedef struct {
        logic        port;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic [63:0] mem_arr [16];
    vec_t        vecs [14];
    exp_t        sb_q [$];
    exp_t        e;
    logic [3:0]  widx;
    logic [7:0]  last_mask;
    int          we_cnt;
    int          n_resp;
    int          n_cmp;
    int          n_fail;

    // Small aliased memory: index = {addr[12], addr[5:3]}.
    assign bus.mem_rd_data = mem_arr[{bus.mem_rd_addr[12], bus.mem_rd_addr[5:3]}];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.r0_req_ready, bus.r1_req_ready, bus.r0_resp_valid, bus.r0_resp_rdata,
                 bus.r1_resp_valid, bus.r1_resp_rdata, bus.r1_resp_err, bus.mem_rd_en,
                 bus.mem_rd_addr, bus.mem_we_en, bus.mem_we_addr, bus.mem_we_data, bus.mem_we_mask};
    endfunction

    task automatic drive_req(input logic port, input logic [63:0] addr, input logic wen,
                             input logic [63:0] wdata, input logic [7:0] wmask);
        bit ok;
        @(posedge clk); #1;
        if (port) begin
            bus.r1_req_valid = 1'b1; bus.r1_req_addr = addr; bus.r1_req_wen = wen;
            bus.r1_req_wdata = wdata; bus.r1_req_wmask = wmask;
        end else begin
            bus.r0_req_valid = 1'b1; bus.r0_req_addr = addr;
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (port ? bus.r1_req_ready : bus.r0_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_handshake", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.r0_req_valid = 1'b0;
        bus.r1_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (n_resp >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("resp_arrived", 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.r0_req_valid = 1'b1;
        bus.r1_req_valid = 1'b1;
        @(negedge clk);
        chk("outputs_in_reset", 64'(any_out()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.r0_req_valid = 1'b0;
        bus.r1_req_valid = 1'b0;
        @(negedge clk);
        chk("outputs_after_reset", 64'(any_out()), 64'd0);
    endtask

    // Both ports request continuously; grants must alternate starting with port 0.
    task automatic rr_run(input int n);
        int k;
        int start;
        k = 0;
        start = n_resp;
        @(posedge clk); #1;
        bus.r0_req_valid = 1'b1; bus.r0_req_addr = 64'h8000_0000;
        bus.r1_req_valid = 1'b1; bus.r1_req_addr = 64'h8000_1000;
        bus.r1_req_wen = 1'b0; bus.r1_req_wmask = 8'h00;
        for (int c = 0; c < 100 && k < n; c++) begin
            @(negedge clk);
            if (bus.r0_req_ready || bus.r1_req_ready) begin
                chk("rr_one_ready", 64'(bus.r0_req_ready & bus.r1_req_ready), 64'd0);
                chk("rr_grant", 64'(bus.r1_req_ready), 64'(k % 2));
                chk("rr_resp_before_grant", 64'(n_resp - start), 64'(k));
                k++;
                if (k == n) begin
                    @(posedge clk); #1;
                end
            end
        end
        bus.r0_req_valid = 1'b0;
        bus.r1_req_valid = 1'b0;
        chk("rr_grants", 64'(k), 64'(n));
        wait_resp(start + n);
    endtask

    initial begin
        int target;
        int we0;
        bit ok;
        rst = 1'b1;
        bus.r0_req_valid = 1'b0; bus.r0_req_addr = '0; bus.r0_resp_ready = 1'b1;
        bus.r1_req_valid = 1'b0; bus.r1_req_addr = '0; bus.r1_req_wen = 1'b0;
        bus.r1_req_wdata = '0; bus.r1_req_wmask = '0; bus.r1_resp_ready = 1'b1;
        n_cmp = 0; n_fail = 0; n_resp = 0; we_cnt = 0; last_mask = 8'h00;
        for (int i = 0; i < 16; i++) mem_arr[i] = 64'hCAFE_0000_0000_0000 | 64'(i);
        mem_arr[0] = 64'h0000_0001_0000_0013;

        vecs[0]  = '{1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h0000_0001_0000_0013, 1'b0, 0};
        vecs[1]  = '{1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 1'b0, 1};
        vecs[2]  = '{1'b1, 64'h8000_1000, 1'b0, 64'h0, 8'h00, 64'hCAFE_0000_DEAD_BEEF, 1'b0, 0};
        vecs[3]  = '{1'b1, 64'h8000_1008, 1'b1, 64'h1122_3344_5566_7788, 8'h05, 64'h0, 1'b1, 0};
        vecs[4]  = '{1'b1, 64'h8000_1008, 1'b0, 64'h0, 8'h00, 64'hCAFE_0000_0000_0009, 1'b0, 0};
        vecs[5]  = '{1'b1, 64'h8000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0, 1};
        vecs[6]  = '{1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, 0};
        vecs[7]  = '{1'b1, 64'h8000_0018, 1'b1, 64'hFFFF_FFFF_FFFF_FFAA, 8'h01, 64'h0, 1'b0, 1};
        vecs[8]  = '{1'b1, 64'h8000_0018, 1'b0, 64'h0, 8'h00, 64'hCAFE_0000_0000_00AA, 1'b0, 0};
        vecs[9]  = '{1'b1, 64'h8000_0020, 1'b1, 64'h1234_5678_9ABC_BEEF, 8'h03, 64'h0, 1'b0, 1};
        vecs[10] = '{1'b0, 64'h8000_0020, 1'b0, 64'h0, 8'h00, 64'hCAFE_0000_0000_BEEF, 1'b0, 0};
        vecs[11] = '{1'b1, 64'h8000_0020, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 1'b1, 0};
        vecs[12] = '{1'b1, 64'h8000_0020, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 64'h0, 1'b1, 0};
        vecs[13] = '{1'b1, 64'h8000_0020, 1'b0, 64'h0, 8'h00, 64'hCAFE_0000_0000_BEEF, 1'b0, 0};

        // Memory model and response scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (bus.mem_we_en) begin
                    widx = {bus.mem_we_addr[12], bus.mem_we_addr[5:3]};
                    for (int b = 0; b < 8; b++)
                        if (bus.mem_we_mask[b]) mem_arr[widx][b*8 +: 8] = bus.mem_we_data[b*8 +: 8];
                    we_cnt++;
                    last_mask = bus.mem_we_mask;
                end
                chk("resp_onehot", 64'(bus.r0_resp_valid & bus.r1_resp_valid), 64'd0);
                if (!bus.r0_resp_valid) chk("r0_rdata_idle", bus.r0_resp_rdata, 64'd0);
                if (!bus.r1_resp_valid) chk("r1_idle", 64'(bus.r1_resp_rdata | 64'(bus.r1_resp_err)), 64'd0);
                if (bus.r0_resp_valid && bus.r0_resp_ready) begin
                    chk("r0_resp_expected", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("r0_resp_port", 64'(e.port), 64'd0);
                        chk("r0_resp_rdata", bus.r0_resp_rdata, e.rdata);
                    end
                    n_resp++;
                end
                if (bus.r1_resp_valid && bus.r1_resp_ready) begin
                    chk("r1_resp_expected", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("r1_resp_port", 64'(e.port), 64'd1);
                        chk("r1_resp_rdata", bus.r1_resp_rdata, e.rdata);
                        chk("r1_resp_err", 64'(bus.r1_resp_err), 64'(e.err));
                    end
                    n_resp++;
                end
            end
        join_none

        do_reset();

        // Cycle-exact fetch read.
        @(posedge clk); #1;
        bus.r0_req_valid = 1'b1; bus.r0_req_addr = 64'h8000_0000;
        sb_q.push_back('{1'b0, 64'h0000_0001_0000_0013, 1'b0});
        @(negedge clk);
        chk("t1_r0_ready", 64'(bus.r0_req_ready), 64'd1);
        chk("t1_r1_ready", 64'(bus.r1_req_ready), 64'd0);
        @(posedge clk); #1;
        bus.r0_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_rd_en", 64'(bus.mem_rd_en), 64'd1);
        chk("t1_rd_addr", bus.mem_rd_addr, 64'h8000_0000);
        chk("t1_early_valid", 64'(bus.r0_resp_valid), 64'd0);
        @(negedge clk);
        chk("t1_resp_valid", 64'(bus.r0_resp_valid), 64'd1);
        chk("t1_resp_rdata", bus.r0_resp_rdata, 64'h0000_0001_0000_0013);
        chk("t1_r1_quiet", 64'(bus.r1_resp_valid | bus.r1_req_ready | bus.r1_resp_err), 64'd0);
        chk("t1_rd_en_off", 64'(bus.mem_rd_en), 64'd0);
        wait_resp(1);

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            we0 = we_cnt;
            target = n_resp + 1;
            sb_q.push_back('{vecs[i].port, vecs[i].exp_rdata, vecs[i].exp_err});
            drive_req(vecs[i].port, vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask);
            wait_resp(target);
            chk("vec_we_pulses", 64'(we_cnt - we0), 64'(vecs[i].exp_we));
            if (vecs[i].exp_we != 0) chk("vec_we_mask", 64'(last_mask), 64'(vecs[i].wmask));
        end

        // Round robin from reset.
        do_reset();
        for (int k = 0; k < 6; k++)
            sb_q.push_back((k % 2) == 0 ? '{1'b0, 64'h0000_0001_0000_0013, 1'b0}
                                        : '{1'b1, 64'hCAFE_0000_DEAD_BEEF, 1'b0});
        rr_run(6);

        // Backpressure on port 0 while port 1 waits.
        target = n_resp + 2;
        sb_q.push_back('{1'b0, 64'h0000_0001_0000_0013, 1'b0});
        sb_q.push_back('{1'b1, 64'h0123_4567_89AB_CDEF, 1'b0});
        bus.r0_resp_ready = 1'b0;
        drive_req(1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00);
        bus.r1_req_valid = 1'b1; bus.r1_req_addr = 64'h8000_0010;
        bus.r1_req_wen = 1'b0; bus.r1_req_wmask = 8'h00;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.r0_resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_resp_seen", 64'(ok), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(bus.r0_resp_valid), 64'd1);
            chk("bp_rdata_held", bus.r0_resp_rdata, 64'h0000_0001_0000_0013);
            chk("bp_r1_blocked", 64'(bus.r1_req_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.r0_resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_r1_blocked_release", 64'(bus.r1_req_ready), 64'd0);
        @(negedge clk);
        chk("bp_r1_accept", 64'(bus.r1_req_ready), 64'd1);
        @(posedge clk); #1;
        bus.r1_req_valid = 1'b0;
        wait_resp(target);

        // Reset during the access cycle of a write.
        we0 = we_cnt;
        target = n_resp;
        drive_req(1'b1, 64'h8000_0028, 1'b1, 64'h5555_5555_5555_5555, 8'hFF);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_we_blocked", 64'(bus.mem_we_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs_zero", 64'(any_out()), 64'd0);
        repeat (4) @(negedge clk);
        chk("rst_no_resp", 64'(n_resp - target), 64'd0);
        chk("rst_no_write", 64'(we_cnt - we0), 64'd0);
        chk("rst_mem_intact", mem_arr[5], 64'hCAFE_0000_0000_0005);
        sb_q.push_back('{1'b0, 64'h0000_0001_0000_0013, 1'b0});
        sb_q.push_back('{1'b1, 64'hCAFE_0000_DEAD_BEEF, 1'b0});
        rr_run(2);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
